// File: rtl/conv_mem_pkg.sv
// ---------------------------------------------------------------------------
// conv_mem_pkg
// Shared constants and types for the convolution memory responder.
//   CSEL_L0 / CSEL_L1 : layer-bank select codes on csel
//   ADDR_W / DATA_W   : address and data widths of every memory port
//   *_DEPTH           : word counts of the image, L0 and L1 memories
//   ARM_TIMEOUT       : ARM cycles without busy before err is raised
//   state_e           : control FSM state encoding
// ---------------------------------------------------------------------------
package conv_mem_pkg;

    localparam logic [2:0]  CSEL_L0     = 3'b001;
    localparam logic [2:0]  CSEL_L1     = 3'b011;
    localparam int unsigned ADDR_W      = 12;
    localparam int unsigned DATA_W      = 20;
    localparam int unsigned IMG_DEPTH   = 4096;
    localparam int unsigned L0_DEPTH    = 4096;
    localparam int unsigned L1_DEPTH    = 1024;
    localparam int unsigned L1_ADDR_W   = $clog2(L1_DEPTH);
    localparam int unsigned ARM_TIMEOUT = 16;
    localparam int unsigned CNT_W       = $clog2(ARM_TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/conv_mem_responder_if.sv
// ---------------------------------------------------------------------------
// conv_mem_responder_if
// Accelerator-side bus of the memory responder.
//   ready / busy                   : start handshake (responder -> accel / accel -> responder)
//   iaddr / idata                  : image read address and pixel
//   cwr / caddr_wr / cdata_wr      : layer-memory write strobe, address, data
//   crd / caddr_rd / cdata_rd      : layer-memory read strobe, address, data
//   csel                           : layer bank select
// Modport master is the accelerator, slave is the responder.
// ---------------------------------------------------------------------------
interface conv_mem_responder_if;
    import conv_mem_pkg::*;

    logic              ready;
    logic              busy;
    logic [ADDR_W-1:0] iaddr;
    logic [DATA_W-1:0] idata;
    logic              cwr;
    logic [ADDR_W-1:0] caddr_wr;
    logic [DATA_W-1:0] cdata_wr;
    logic              crd;
    logic [ADDR_W-1:0] caddr_rd;
    logic [DATA_W-1:0] cdata_rd;
    logic [2:0]        csel;

    modport master (
        input  ready, idata, cdata_rd,
        output busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
    );

    modport slave (
        output ready, idata, cdata_rd,
        input  busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
    );

endinterface

// File: rtl/conv_sram.sv
// ---------------------------------------------------------------------------
// conv_sram
// Register-file memory: one synchronous write port, NumRd asynchronous reads.
//   clk          : write clock
//   we/waddr/wdata : write strobe, address, data (written on rising edge)
//   raddr/rdata  : NumRd combinational read ports
// A read of an address being written in the same cycle returns the old word.
// Contents are never reset. Depth must be a power of two.
// ---------------------------------------------------------------------------
module conv_sram #(
    parameter int unsigned Depth = 1024,
    parameter int unsigned Width = 20,
    parameter int unsigned NumRd = 1,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [AddrW-1:0]           waddr,
    input  logic [Width-1:0]           wdata,
    input  logic [NumRd-1:0][AddrW-1:0] raddr,
    output logic [NumRd-1:0][Width-1:0] rdata
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        for (int i = 0; i < NumRd; i++) begin
            rdata[i] = mem[raddr[i]];
        end
    end

endmodule

// File: rtl/conv_mem_responder.sv
// ---------------------------------------------------------------------------
// conv_mem_responder
// Host-loaded image memory plus two layer memories (L0 4096x20, L1 1024x20)
// serving a convolution accelerator, with a start/ready/busy/done handshake.
//   clk, reset              : clock, asynchronous active-low reset
//   bus (slave)             : accelerator bus, see conv_mem_responder_if
//   ld_we/ld_addr/ld_data   : host image load (honoured only in IDLE)
//   start / done            : host run request / one-cycle completion pulse
//   rd_sel/rd_addr/rd_data  : host result readback (registered, IDLE only)
//   err                     : sticky error, cleared by an accepted start
// Optional macro CONV_MEM_RANGE_CHECK_EN: flag and drop bad csel/L1 accesses.
// ---------------------------------------------------------------------------
module conv_mem_responder
    import conv_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    conv_mem_responder_if.slave   bus,
    input  logic                  ld_we,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [DATA_W-1:0]     ld_data,
    input  logic                  start,
    output logic                  done,
    input  logic                  rd_sel,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  err
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   arm_cnt_q, arm_cnt_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               arm_timeout;
    logic               range_err;
    logic               is_idle;

    logic                            sel_l0, sel_l1;
    logic                            img_we, l0_we, l1_we;
    logic [0:0][ADDR_W-1:0]          img_raddr;
    logic [0:0][DATA_W-1:0]          img_rdata;
    logic [1:0][ADDR_W-1:0]          l0_raddr;
    logic [1:0][DATA_W-1:0]          l0_rdata;
    logic [1:0][L1_ADDR_W-1:0]       l1_raddr;
    logic [1:0][DATA_W-1:0]          l1_rdata;

    assign is_idle = (state_q == StIdle);
    assign sel_l0  = (bus.csel == CSEL_L0);
    assign sel_l1  = (bus.csel == CSEL_L1);

`ifdef CONV_MEM_RANGE_CHECK_EN
    logic wr_bad, rd_bad;
    assign wr_bad = bus.cwr && (!(sel_l0 || sel_l1) ||
                                (sel_l1 && (bus.caddr_wr[ADDR_W-1:L1_ADDR_W] != '0)));
    assign rd_bad = bus.crd && (!(sel_l0 || sel_l1) ||
                                (sel_l1 && (bus.caddr_rd[ADDR_W-1:L1_ADDR_W] != '0)));
    assign range_err = wr_bad || rd_bad;
    assign l1_we     = bus.cwr && sel_l1 && !wr_bad;
`else
    // Without checking, L1 simply wraps on the low address bits.
    assign range_err = 1'b0;
    assign l1_we     = bus.cwr && sel_l1;
`endif

    // Layer writes are independent of the FSM; image loads only in IDLE.
    assign l0_we  = bus.cwr && sel_l0;
    assign img_we = ld_we && is_idle;

    assign img_raddr[0] = bus.iaddr;
    assign l0_raddr[0]  = bus.caddr_rd;
    assign l0_raddr[1]  = rd_addr;
    assign l1_raddr[0]  = bus.caddr_rd[L1_ADDR_W-1:0];
    assign l1_raddr[1]  = rd_addr[L1_ADDR_W-1:0];

    conv_sram #(
        .Depth (IMG_DEPTH),
        .Width (DATA_W),
        .NumRd (1)
    ) u_img (
        .clk   (clk),
        .we    (img_we),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (img_raddr),
        .rdata (img_rdata)
    );

    conv_sram #(
        .Depth (L0_DEPTH),
        .Width (DATA_W),
        .NumRd (2)
    ) u_l0 (
        .clk   (clk),
        .we    (l0_we),
        .waddr (bus.caddr_wr),
        .wdata (bus.cdata_wr),
        .raddr (l0_raddr),
        .rdata (l0_rdata)
    );

    conv_sram #(
        .Depth (L1_DEPTH),
        .Width (DATA_W),
        .NumRd (2)
    ) u_l1 (
        .clk   (clk),
        .we    (l1_we),
        .waddr (bus.caddr_wr[L1_ADDR_W-1:0]),
        .wdata (bus.cdata_wr),
        .raddr (l1_raddr),
        .rdata (l1_rdata)
    );

    // Accelerator-facing read data is purely combinational.
    assign bus.idata = img_rdata[0];

    always_comb begin
        bus.cdata_rd = '0;
        if (bus.crd) begin
            if (sel_l0) begin
                bus.cdata_rd = l0_rdata[0];
            end else if (sel_l1) begin
                bus.cdata_rd = l1_rdata[0];
            end
        end
    end

    // Control FSM next state.
    always_comb begin
        state_d     = state_q;
        arm_cnt_d   = arm_cnt_q;
        arm_timeout = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StArm;
                    arm_cnt_d = '0;
                end
            end
            StArm: begin
                if (bus.busy) begin
                    state_d = StRun;
                end else if (arm_cnt_q == CNT_W'(ARM_TIMEOUT - 1)) begin
                    state_d     = StIdle;
                    arm_timeout = 1'b1;
                end else begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (!bus.busy) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Error flag: start clears it, any new error sets it (set wins).
    always_comb begin
        err_d = err_q;
        if (is_idle && start) begin
            err_d = 1'b0;
        end
        if (arm_timeout || range_err) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (is_idle) begin
            rd_data_d = rd_sel ? l1_rdata[1] : l0_rdata[1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            arm_cnt_q <= '0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.ready = (state_q == StArm);
    assign done      = (state_q == StDone);
    assign err       = err_q;
    // Hide the word captured on the last IDLE cycle once the FSM has left IDLE.
    assign rd_data   = is_idle ? rd_data_q : '0;

endmodule

// File: tb/tb_conv_mem_responder.sv
module tb_conv_mem_responder;
    import conv_mem_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ld_we = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              start = 1'b0;
    logic              done;
    logic              rd_sel = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              err;

    conv_mem_responder_if bus ();

    conv_mem_responder dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .ld_we   (ld_we),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .start   (start),
        .done    (done),
        .rd_sel  (rd_sel),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .err     (err)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_v;

`ifdef CONV_MEM_RANGE_CHECK_EN
    localparam logic [DATA_W-1:0] L1_5_EXP = 20'h12345;
`else
    localparam logic [DATA_W-1:0] L1_5_EXP = 20'h0CCCC;
`endif

    task automatic test_reset();
        #3 reset = 1'b0;
        #1;
        n_tests++;
        if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", bus.ready); end
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        n_tests++;
        if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        n_tests++;
        if (dut.state_q !== StIdle) begin
            n_fail++; $display("FAIL reset_state got %0d want %0d", dut.state_q, StIdle);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_load();
        logic [ADDR_W-1:0] probe [4];
        probe[0] = 12'h000; probe[1] = 12'h7FF; probe[2] = 12'hFFF; probe[3] = 12'h123;
        for (int a = 0; a < 4096; a++) begin
            @(negedge clk);
            ld_we = 1'b1; ld_addr = ADDR_W'(a); ld_data = DATA_W'(a);
        end
        @(negedge clk);
        ld_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.iaddr = probe[i];
            exp_q.push_back(DATA_W'(probe[i]));
            #1;
            exp_v = exp_q.pop_front();
            n_tests++;
            if (bus.idata !== exp_v) begin
                n_fail++; $display("FAIL img_read addr %h got %h want %h", probe[i], bus.idata, exp_v);
            end
        end
    endtask

    task automatic test_layer_mem();
        @(negedge clk);
        bus.cwr = 1'b1; bus.csel = CSEL_L0; bus.caddr_wr = 12'h005; bus.cdata_wr = 20'hABCDE;
        @(negedge clk);
        bus.csel = CSEL_L1; bus.cdata_wr = 20'h11111;
        @(negedge clk);
        bus.cwr = 1'b0; bus.crd = 1'b1; bus.caddr_rd = 12'h005;
        #1;
        n_tests++;
        if (bus.cdata_rd !== 20'h11111) begin
            n_fail++; $display("FAIL l1_read got %h want 11111", bus.cdata_rd);
        end
        // Write and read the same word in one cycle: old now, new next cycle.
        @(negedge clk);
        bus.cwr = 1'b1; bus.caddr_wr = 12'h005; bus.cdata_wr = 20'h12345;
        exp_q.push_back(20'h11111);
        exp_q.push_back(20'h12345);
        #1;
        exp_v = exp_q.pop_front();
        n_tests++;
        if (bus.cdata_rd !== exp_v) begin
            n_fail++; $display("FAIL l1_same_cycle got %h want %h", bus.cdata_rd, exp_v);
        end
        @(negedge clk);
        bus.cwr = 1'b0;
        #1;
        exp_v = exp_q.pop_front();
        n_tests++;
        if (bus.cdata_rd !== exp_v) begin
            n_fail++; $display("FAIL l1_next_cycle got %h want %h", bus.cdata_rd, exp_v);
        end
        bus.crd = 1'b0;
        #1;
        n_tests++;
        if (bus.cdata_rd !== '0) begin n_fail++; $display("FAIL crd_low got %h want 0", bus.cdata_rd); end
        // Unmapped select must not write either bank.
        @(negedge clk);
        bus.cwr = 1'b1; bus.csel = 3'b010; bus.cdata_wr = 20'hFFFFF;
        @(negedge clk);
        bus.cwr = 1'b0; bus.crd = 1'b1; bus.csel = CSEL_L0; bus.caddr_rd = 12'h005;
        #1;
        n_tests++;
        if (bus.cdata_rd !== 20'hABCDE) begin
            n_fail++; $display("FAIL l0_after_badsel got %h want abcde", bus.cdata_rd);
        end
        bus.csel = CSEL_L1;
        #1;
        n_tests++;
        if (bus.cdata_rd !== 20'h12345) begin
            n_fail++; $display("FAIL l1_after_badsel got %h want 12345", bus.cdata_rd);
        end
`ifndef CONV_MEM_RANGE_CHECK_EN
        @(negedge clk);
        bus.cwr = 1'b1; bus.caddr_wr = 12'h405; bus.cdata_wr = 20'h0CCCC;
        @(negedge clk);
        bus.cwr = 1'b0;
        #1;
        n_tests++;
        if (bus.cdata_rd !== 20'h0CCCC) begin
            n_fail++; $display("FAIL l1_wrap got %h want 0cccc", bus.cdata_rd);
        end
`endif
        bus.crd = 1'b0;
    endtask

    task automatic test_handshake();
        int rdy_cnt = 0;
        int dn_cnt = 0;
        @(negedge clk);
        rd_sel = 1'b0; rd_addr = 12'h005; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.ready) rdy_cnt++;
            if (i == 2) bus.busy = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (rdy_cnt != 3) begin n_fail++; $display("FAIL ready_cycles got %0d want 3", rdy_cnt); end
        n_tests++;
        if (dut.state_q !== StRun) begin
            n_fail++; $display("FAIL state_run got %0d want %0d", dut.state_q, StRun);
        end
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_cleared got %b want 0", err); end
        n_tests++;
        if (rd_data !== '0) begin n_fail++; $display("FAIL rd_data_run got %h want 0", rd_data); end
        bus.iaddr = 12'h041;
        exp_q.push_back(20'h00041);
        #1;
        exp_v = exp_q.pop_front();
        n_tests++;
        if (bus.idata !== exp_v) begin n_fail++; $display("FAIL idata_run got %h want %h", bus.idata, exp_v); end
        // Image loads and start are ignored outside IDLE; layer writes are not.
        ld_we = 1'b1; ld_addr = 12'h041; ld_data = 20'hFFFFF; start = 1'b1;
        bus.cwr = 1'b1; bus.csel = CSEL_L0; bus.caddr_wr = 12'h006; bus.cdata_wr = 20'h55555;
        @(negedge clk);
        ld_we = 1'b0; start = 1'b0; bus.cwr = 1'b0;
        #1;
        n_tests++;
        if (bus.idata !== 20'h00041) begin
            n_fail++; $display("FAIL ld_we_ignored got %h want 00041", bus.idata);
        end
        n_tests++;
        if (dut.state_q !== StRun) begin
            n_fail++; $display("FAIL start_ignored got %0d want %0d", dut.state_q, StRun);
        end
        bus.busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dn_cnt++;
        end
        n_tests++;
        if (dn_cnt != 1) begin n_fail++; $display("FAIL done_pulse got %0d want 1", dn_cnt); end
        n_tests++;
        if (dut.state_q !== StIdle) begin
            n_fail++; $display("FAIL state_after_done got %0d want %0d", dut.state_q, StIdle);
        end
        n_tests++;
        if (rd_data !== 20'hABCDE) begin n_fail++; $display("FAIL rd_l0_5 got %h want abcde", rd_data); end
        rd_addr = 12'h006;
        exp_q.push_back(20'h55555);
        #1;
        n_tests++;
        if (rd_data !== 20'hABCDE) begin n_fail++; $display("FAIL rd_latency got %h want abcde", rd_data); end
        @(negedge clk);
        exp_v = exp_q.pop_front();
        n_tests++;
        if (rd_data !== exp_v) begin n_fail++; $display("FAIL rd_l0_6 got %h want %h", rd_data, exp_v); end
        rd_sel = 1'b1; rd_addr = 12'hC05;
        exp_q.push_back(L1_5_EXP);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        n_tests++;
        if (rd_data !== exp_v) begin n_fail++; $display("FAIL rd_l1_5 got %h want %h", rd_data, exp_v); end
        rd_sel = 1'b0;
    endtask

    task automatic test_timeout();
        int rdy_cnt = 0;
        bit hit = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (err) begin hit = 1'b1; break; end
            if (bus.ready) rdy_cnt++;
            @(negedge clk);
        end
        n_tests++;
        if (!hit) begin n_fail++; $display("FAIL timeout_err got 0 want 1 within 40 cycles"); end
        n_tests++;
        if (rdy_cnt != 16) begin n_fail++; $display("FAIL timeout_cycles got %0d want 16", rdy_cnt); end
        n_tests++;
        if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL timeout_ready got %b want 0", bus.ready); end
        n_tests++;
        if (dut.state_q !== StIdle) begin
            n_fail++; $display("FAIL timeout_state got %0d want %0d", dut.state_q, StIdle);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL restart_clears_err got %b want 0", err); end
        bus.busy = 1'b1;
        @(negedge clk);
        bus.busy = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (dut.state_q !== StIdle) begin
            n_fail++; $display("FAIL restart_idle got %0d want %0d", dut.state_q, StIdle);
        end
    endtask

`ifdef CONV_MEM_RANGE_CHECK_EN
    task automatic test_range_check();
        @(negedge clk);
        bus.cwr = 1'b1; bus.csel = CSEL_L1; bus.caddr_wr = 12'h000; bus.cdata_wr = 20'h0AAAA;
        @(negedge clk);
        bus.caddr_wr = 12'h400; bus.cdata_wr = 20'h0BBBB;
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL range_good_write got %b want 0", err); end
        @(negedge clk);
        bus.cwr = 1'b0; bus.crd = 1'b1; bus.caddr_rd = 12'h000;
        n_tests++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL range_err got %b want 1", err); end
        #1;
        n_tests++;
        if (bus.cdata_rd !== 20'h0AAAA) begin
            n_fail++; $display("FAIL range_dropped got %h want 0aaaa", bus.cdata_rd);
        end
        bus.crd = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_run();
        int dn_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; bus.busy = 1'b1;
        @(negedge clk);
        n_tests++;
        if (dut.state_q !== StRun) begin
            n_fail++; $display("FAIL mid_run_state got %0d want %0d", dut.state_q, StRun);
        end
        #2 reset = 1'b0;
        bus.busy = 1'b0;
        #1;
        n_tests++;
        if (dut.state_q !== StIdle) begin
            n_fail++; $display("FAIL mid_run_abort got %0d want %0d", dut.state_q, StIdle);
        end
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL mid_run_err got %b want 0", err); end
        for (int i = 0; i < 6; i++) begin
            if (i == 3) reset = 1'b1;
            @(negedge clk);
            if (done) dn_cnt++;
        end
        n_tests++;
        if (dn_cnt != 0) begin n_fail++; $display("FAIL mid_run_done got %0d want 0", dn_cnt); end
        bus.iaddr = 12'h041; bus.crd = 1'b1; bus.csel = CSEL_L0; bus.caddr_rd = 12'h005;
        #1;
        n_tests++;
        if (bus.idata !== 20'h00041) begin n_fail++; $display("FAIL img_kept got %h want 00041", bus.idata); end
        n_tests++;
        if (bus.cdata_rd !== 20'hABCDE) begin
            n_fail++; $display("FAIL l0_kept got %h want abcde", bus.cdata_rd);
        end
        bus.crd = 1'b0;
    endtask

    initial begin
        bus.busy = 1'b0; bus.iaddr = '0; bus.cwr = 1'b0; bus.caddr_wr = '0; bus.cdata_wr = '0;
        bus.crd = 1'b0; bus.caddr_rd = '0; bus.csel = '0;
        test_reset();
        test_load();
        test_layer_mem();
        test_handshake();
        test_timeout();
`ifdef CONV_MEM_RANGE_CHECK_EN
        test_range_check();
`endif
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_mem_responder.md
CONV_MEM_RESPONDER -- requirements
Module: conv_mem_responder

Interface
REQ-001 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 Port reset, input, 1, asynchronous active-low reset; the block is in reset while reset=0.
REQ-003 Port ready, output, 1, start request to the accelerator.
REQ-004 Port busy, input, 1, accelerator run indication.
REQ-005 Port iaddr, input, 12, image read address; port idata, output, 20, image pixel.
REQ-006 Ports cwr (input, 1), caddr_wr (input, 12) and cdata_wr (input, 20) form the layer-memory write strobe, address and data.
REQ-007 Ports crd (input, 1), caddr_rd (input, 12) and cdata_rd (output, 20) form the layer-memory read strobe, address and data.
REQ-008 Port csel, input, 3, bank select: 3'b001 = L0 (4096x20), 3'b011 = L1 (1024x20).
REQ-009 Ports ld_we (input, 1), ld_addr (input, 12) and ld_data (input, 20) form the host image-load port.
REQ-010 Ports start (input, 1) and done (output, 1, one-cycle pulse) form the host control.
REQ-011 Ports rd_sel (input, 1; 0 = L0, 1 = L1), rd_addr (input, 12) and rd_data (output, 20) form the host result readback.
REQ-012 Port err, output, 1, sticky error flag.

Function
REQ-013 The FSM SHALL have states IDLE, ARM, RUN and DONE; reset state is IDLE.
REQ-014 IDLE: ld_we=1 SHALL write ld_data to img[ld_addr] at the clock edge; ld_we SHALL be ignored in every other state.
REQ-015 IDLE with start=1 SHALL go to ARM and clear err; start SHALL be ignored outside IDLE.
REQ-016 ARM SHALL drive ready=1 and go to RUN on the first cycle busy=1; ready SHALL be 0 in every other state.
REQ-017 ARM SHALL count cycles; after 16 cycles with busy=0 it SHALL set err=1 and return to IDLE.
REQ-018 RUN with busy=0 SHALL go to DONE; DONE SHALL assert done=1 for exactly one cycle and then go to IDLE.
REQ-019 idata SHALL equal img[iaddr] combinationally, with zero latency, so the accelerator samples it on the edge after driving iaddr.
REQ-020 cdata_rd SHALL equal the selected bank at caddr_rd combinationally when crd=1, and 0 when crd=0.
REQ-021 cwr=1 with csel=001 SHALL write cdata_wr to L0[caddr_wr]; with csel=011 it SHALL write to L1[caddr_wr[9:0]]; other csel values SHALL be ignored.
REQ-022 A same-cycle write and read to the same bank and address SHALL return the old data; the new data SHALL be visible from the next cycle.
REQ-023 Layer writes SHALL be accepted in every state; they are not gated by the FSM.
REQ-024 rd_data SHALL be registered with one-cycle latency and SHALL be valid only in IDLE; it SHALL read 0 otherwise.
REQ-025 rd_sel=1 SHALL use rd_addr[9:0]; rd_addr[11:10] SHALL be ignored.

Reset
REQ-026 Asserting reset SHALL set ready=0, done=0, err=0, rd_data=0, FSM=IDLE and the ARM counter to 0; memory contents SHALL NOT be cleared.
REQ-027 Reset asserted mid-RUN SHALL abort to IDLE without a done pulse.

Configuration
REQ-028 Macro CONV_MEM_RANGE_CHECK_EN defined: err SHALL set when cwr or crd is active with csel other than 001/011, or with csel=011 and address[11:10]!=0; the offending write SHALL be dropped.
REQ-029 Macro CONV_MEM_RANGE_CHECK_EN undefined: no range or select checking; err SHALL come from the ARM timeout only; L1 addresses wrap mod 1024.

Structure
REQ-030 Package conv_mem_pkg SHALL hold CSEL_L0=3'b001, CSEL_L1=3'b011, ADDR_W=12, DATA_W=20, L1_DEPTH=1024, ARM_TIMEOUT=16 and the FSM state enum.
REQ-031 Sub-module conv_sram (parameterised depth, one synchronous write port, async read ports) SHALL be instantiated for img, L0 and L1.

Verification
REQ-032 Load img[0..4095]=addr, pulse start, raise busy 3 cycles later -> ready=1 for exactly 3 cycles, then FSM in RUN.
REQ-033 In RUN, drive iaddr=0x041 -> idata=0x00041 in the same cycle.
REQ-034 Write csel=011, caddr_wr=0x005, cdata_wr=0x12345, then read csel=011 caddr_rd=0x005 with crd=1 -> cdata_rd=0x12345 on the next cycle; a same-cycle read returns old data.
REQ-035 Drop busy -> done=1 for one cycle, then IDLE; rd_sel=0, rd_addr=0x005 -> rd_data=L0[5] one cycle later.
REQ-036 Start with busy held at 0 -> err=1 after 16 cycles, ready=0, FSM=IDLE.
REQ-037 With CONV_MEM_RANGE_CHECK_EN defined, write csel=011 caddr_wr=0x400 -> err=1 and L1[0] unchanged; assert reset mid-RUN -> done stays 0.
